// File: rtl/maze_pkg.sv
// Shared widths, key codes, direction and FSM encodings for the maze walker.
package maze_pkg;

   localparam int unsigned COLS_DEF = 32;
   localparam int unsigned ROWS_DEF = 24;
   localparam int unsigned ROW_W    = 5;
   localparam int unsigned COL_W    = 5;
   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned CODE_W   = 9;
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned KEYS_W   = 512;

   localparam logic [CODE_W-1:0] KEY_W     = 9'h01D;
   localparam logic [CODE_W-1:0] KEY_A     = 9'h01C;
   localparam logic [CODE_W-1:0] KEY_S     = 9'h01B;
   localparam logic [CODE_W-1:0] KEY_D     = 9'h023;
   localparam logic [CODE_W-1:0] KEY_UP    = 9'h175;
   localparam logic [CODE_W-1:0] KEY_LEFT  = 9'h16B;
   localparam logic [CODE_W-1:0] KEY_DOWN  = 9'h172;
   localparam logic [CODE_W-1:0] KEY_RIGHT = 9'h174;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } cell_t;

endpackage

// File: rtl/maze_walker_if.sv
// Keyboard, wall-ROM and position/status signals of the maze walker.
interface maze_walker_if;
   import maze_pkg::*;

   logic                key_valid;
   logic [CODE_W-1:0]   last_change;
   logic [KEYS_W-1:0]   key_down;
   logic [ADDR_W-1:0]   wall_addr;
   logic                wall_bit;
   logic [ROW_W-1:0]    row;
   logic [COL_W-1:0]    column;
   logic                move;
   logic                bump;
   logic [CNT_W-1:0]    move_count;
   logic                game_state;

   modport slave (
      input  key_valid, last_change, key_down, wall_bit,
      output wall_addr, row, column, move, bump, move_count, game_state
   );

   modport master (
      output key_valid, last_change, key_down, wall_bit,
      input  wall_addr, row, column, move, bump, move_count, game_state
   );

endinterface

// File: rtl/maze_key_decode.sv
// Maps a key press to a move direction. Extended arrows are accepted only
// when ARROW_KEYS_EN is defined.
module maze_key_decode
   import maze_pkg::*;
(
   input  logic [CODE_W-1:0] last_change,
   input  logic [KEYS_W-1:0] key_down,
   output logic              dir_valid_c,
   output dir_t              dir_c
);

   always_comb begin
      dir_valid_c = 1'b0;
      dir_c       = DIR_UP;
      if (key_down[last_change]) begin
         case (last_change)
            KEY_W:     begin dir_valid_c = 1'b1; dir_c = DIR_UP;    end
            KEY_A:     begin dir_valid_c = 1'b1; dir_c = DIR_LEFT;  end
            KEY_S:     begin dir_valid_c = 1'b1; dir_c = DIR_DOWN;  end
            KEY_D:     begin dir_valid_c = 1'b1; dir_c = DIR_RIGHT; end
`ifdef ARROW_KEYS_EN
            KEY_UP:    begin dir_valid_c = 1'b1; dir_c = DIR_UP;    end
            KEY_LEFT:  begin dir_valid_c = 1'b1; dir_c = DIR_LEFT;  end
            KEY_DOWN:  begin dir_valid_c = 1'b1; dir_c = DIR_DOWN;  end
            KEY_RIGHT: begin dir_valid_c = 1'b1; dir_c = DIR_RIGHT; end
`else
`endif
            default:   begin dir_valid_c = 1'b0; dir_c = DIR_UP;    end
         endcase
      end
   end

endmodule

// File: rtl/maze_walker.sv
// Player position tracker: validates each key move against maze bounds and a
// wall ROM, then drives position, move/bump strobes, move counter and goal flag.
module maze_walker
   import maze_pkg::*;
#(
   parameter int unsigned COLS      = COLS_DEF,
   parameter int unsigned ROWS      = ROWS_DEF,
   parameter int unsigned START_ROW = 0,
   parameter int unsigned START_COL = 0,
   parameter int unsigned GOAL_ROW  = 23,
   parameter int unsigned GOAL_COL  = 31
)
(
   input  logic          clk,
   input  logic          rst,
   maze_walker_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state;
   cell_t              tgt;
   logic               dir_valid_c;
   dir_t               dir_c;
   logic signed [5:0]  nr_c;
   logic signed [5:0]  nc_c;
   logic               oob_c;
   logic [ADDR_W-1:0]  addr_c;

   maze_key_decode u_decode (
      .last_change (bus.last_change),
      .key_down    (bus.key_down),
      .dir_valid_c (dir_valid_c),
      .dir_c       (dir_c)
   );

   // Candidate cell in 6-bit signed space so stepping off either edge shows up as negative.
   always_comb begin
      nr_c = $signed({1'b0, bus.row});
      nc_c = $signed({1'b0, bus.column});
      case (dir_c)
         DIR_UP:    nr_c = nr_c - 6'sd1;
         DIR_DOWN:  nr_c = nr_c + 6'sd1;
         DIR_LEFT:  nc_c = nc_c - 6'sd1;
         DIR_RIGHT: nc_c = nc_c + 6'sd1;
         default:   nr_c = nr_c;
      endcase
      oob_c  = nr_c[5] || (nr_c[4:0] > 5'(ROWS - 1)) ||
               nc_c[5] || (nc_c[4:0] > 5'(COLS - 1));
      addr_c = ADDR_W'(nr_c[4:0]) * ADDR_W'(COLS) + ADDR_W'(nc_c[4:0]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ST_IDLE;
         tgt            <= '0;
         bus.wall_addr  <= '0;
         bus.row        <= ROW_W'(START_ROW);
         bus.column     <= COL_W'(START_COL);
         bus.move       <= 1'b0;
         bus.bump       <= 1'b0;
         bus.move_count <= '0;
         bus.game_state <= 1'b0;
      end else begin
         bus.move <= 1'b0;
         bus.bump <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.key_valid && dir_valid_c) begin
                  if (oob_c) begin
                     bus.bump <= 1'b1;
                  end else begin
                     tgt.row       <= nr_c[4:0];
                     tgt.col       <= nc_c[4:0];
                     bus.wall_addr <= addr_c;
                     state         <= ST_REQ;
                  end
               end
            end
            // ROM sees wall_addr this cycle; its data arrives during WAIT.
            ST_REQ: state <= ST_WAIT;
            ST_WAIT: begin
               if (bus.wall_bit) begin
                  bus.bump <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  bus.row    <= tgt.row;
                  bus.column <= tgt.col;
                  bus.move   <= 1'b1;
                  if (bus.move_count != CNT_MAX)
                     bus.move_count <= bus.move_count + CNT_W'(1);
                  if (tgt.row == ROW_W'(GOAL_ROW) && tgt.col == COL_W'(GOAL_COL)) begin
                     bus.game_state <= 1'b1;
                     state          <= ST_DONE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DONE: bus.game_state <= 1'b1;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_walker.sv
// Directed + randomized bench for maze_walker with a 1-cycle-latency wall ROM
// and a move-by-move reference model of the maze rules.
module tb_maze_walker;
   import maze_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maze_walker_if bus ();

   maze_walker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   bit walls [1024];
   always @(posedge clk) bus.wall_bit <= walls[bus.wall_addr];

   int tests  = 0;
   int failed = 0;
   int m_r, m_c, m_cnt;
   bit m_done;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dir_of(input logic [8:0] code);
      case (code)
         9'h01D: return 0;
         9'h01C: return 1;
         9'h01B: return 2;
         9'h023: return 3;
`ifdef ARROW_KEYS_EN
         9'h175: return 0;
         9'h16B: return 1;
         9'h172: return 2;
         9'h174: return 3;
`endif
         default: return -1;
      endcase
   endfunction

   task automatic clear_walls();
      for (int i = 0; i < 1024; i++) walls[i] = 1'b0;
   endtask

   task automatic rand_keys();
      for (int i = 0; i < 16; i++) bus.key_down[i*32 +: 32] = $urandom();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_r = 0; m_c = 0; m_cnt = 0; m_done = 1'b0;
      check("rst_row",   int'(bus.row), 0);
      check("rst_col",   int'(bus.column), 0);
      check("rst_move",  int'(bus.move), 0);
      check("rst_bump",  int'(bus.bump), 0);
      check("rst_count", int'(bus.move_count), 0);
      check("rst_gs",    int'(bus.game_state), 0);
      check("rst_addr",  int'(bus.wall_addr), 0);
   endtask

   // One key event (held for 'hold' cycles), observed over the following five cycles.
   task automatic step(input logic [8:0] code, input bit dn, input int hold);
      int kind, er, ec, dr, dc, d;
      int mv_k, bp_k, mv_n, bp_n, both, prev_addr, addr_k1, gs_mv;
      d = dir_of(code);
      er = m_r; ec = m_c; kind = 0;
      if (!m_done && dn && d >= 0) begin
         dr = (d == 0) ? -1 : (d == 2) ? 1 : 0;
         dc = (d == 1) ? -1 : (d == 3) ? 1 : 0;
         er = m_r + dr;
         ec = m_c + dc;
         if (er < 0 || er >= 24 || ec < 0 || ec >= 32) kind = 2;
         else if (walls[er*32 + ec])                   kind = 3;
         else                                          kind = 1;
      end
      mv_k = 0; bp_k = 0; mv_n = 0; bp_n = 0; both = 0; addr_k1 = 0; gs_mv = 0;
      prev_addr = int'(bus.wall_addr);
      @(negedge clk);
      rand_keys();
      bus.key_down[code] = dn;
      bus.last_change    = code;
      bus.key_valid      = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         bus.key_valid = (k < hold);
         if (k == 1) addr_k1 = int'(bus.wall_addr);
         if (bus.move) begin mv_n++; mv_k = k; gs_mv = int'(bus.game_state); end
         if (bus.bump) begin bp_n++; bp_k = k; end
         if (bus.move && bus.bump) both++;
      end
      if (kind == 1) begin
         m_r = er; m_c = ec;
         if (m_cnt < 1023) m_cnt++;
         if (er == 23 && ec == 31) m_done = 1'b1;
      end
      check("move_cycle",  mv_k, (kind == 1) ? 3 : 0);
      check("move_pulses", mv_n, (kind == 1) ? 1 : 0);
      check("bump_cycle",  bp_k, (kind == 2) ? 1 : (kind == 3) ? 3 : 0);
      check("bump_pulses", bp_n, (kind == 2 || kind == 3) ? 1 : 0);
      check("move_bump_overlap", both, 0);
      check("wall_addr", addr_k1, (kind == 1 || kind == 3) ? er*32 + ec : prev_addr);
      check("row",        int'(bus.row), m_r);
      check("column",     int'(bus.column), m_c);
      check("move_count", int'(bus.move_count), m_cnt);
      check("game_state", int'(bus.game_state), int'(m_done));
      if (kind == 1) check("gs_with_move", gs_mv, int'(m_done));
   endtask

   initial begin
      logic [8:0] pool [10];
      pool[0] = KEY_W;  pool[1] = KEY_A;    pool[2] = KEY_S;    pool[3] = KEY_D;
      pool[4] = KEY_UP; pool[5] = KEY_LEFT; pool[6] = KEY_DOWN; pool[7] = KEY_RIGHT;
      pool[8] = 9'h11D; pool[9] = 9'h05A;

      rst = 1'b0;
      bus.key_valid   = 1'b0;
      bus.last_change = '0;
      bus.key_down    = '0;
      clear_walls();
      repeat (2) @(negedge clk);
      do_reset();

      // Boundary hits at the origin, then a wall hit below it.
      step(KEY_W, 1'b1, 1);
      step(KEY_A, 1'b1, 1);
      walls[1*32 + 0] = 1'b1;
      step(KEY_S, 1'b1, 1);

      // Open move right, then a press repeated during REQ/WAIT, then releases.
      step(KEY_D, 1'b1, 1);
      step(KEY_D, 1'b1, 3);
      step(KEY_D, 1'b0, 1);
      step(KEY_S, 1'b0, 1);

      // Random walls and random key traffic.
      clear_walls();
      for (int i = 0; i < 768; i++) walls[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 60; i++)
         step(pool[$urandom_range(0, 9)], ($urandom_range(0, 3) != 0), 1);

      // Open path to the goal; keys are ignored afterwards until reset.
      do_reset();
      clear_walls();
      for (int i = 0; i < 31; i++) step(KEY_D, 1'b1, 1);
      for (int i = 0; i < 23; i++) step(KEY_S, 1'b1, 1);
      step(KEY_W, 1'b1, 1);
      step(KEY_D, 1'b1, 1);
      do_reset();

      // Extended right arrow.
      step(KEY_RIGHT, 1'b1, 1);
      step(KEY_D, 1'b1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
